// File: rtl/ram_be_packer.sv
// ram_be_packer: packs a byte stream into byte-enabled RAM word writes.
// Ports: clk, rst_n; start_i/base_addr_i/len_i job setup; byte_val_i/
// byte_dat_i/byte_rdy_o byte stream; cen_o/wen_o/addr_o/data_o RAM
// write port (low-active strobes); busy_o, done_o, ovf_o status.
// Build option: PACK_ADDR_WRAP_EN lets the word address wrap to 0
// instead of ending the job with ovf_o.
module ram_be_packer #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [Addr_Width-1:0]   base_addr_i,
  input  logic [15:0]             len_i,
  input  logic                    byte_val_i,
  input  logic [7:0]              byte_dat_i,
  output logic                    byte_rdy_o,
  output logic                    cen_o,
  output logic [Word_Width/8-1:0] wen_o,
  output logic [Addr_Width-1:0]   addr_o,
  output logic [Word_Width-1:0]   data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o
);

  localparam int Byte_Width = Word_Width / 8;
  localparam int Lane_Bits  =
    (Byte_Width > 1) ? $clog2(Byte_Width) : 1;

  typedef enum logic [1:0] {
    IDLE, PACK, FLUSH, DONE
  } state_t;

  state_t                state;
  logic [15:0]           cnt;
  logic [15:0]           len;
  logic [Lane_Bits-1:0]  lane;
  logic [Addr_Width-1:0] waddr;
  logic [Word_Width-1:0] acc;
  logic [Byte_Width-1:0] mask;

  logic [Word_Width-1:0] acc_nxt;
  logic [Byte_Width-1:0] mask_nxt;
  logic                  fire;
  logic                  last;
  logic                  full;

  assign fire = byte_val_i & byte_rdy_o;
  assign last = (cnt + 16'd1) == len;
  assign full = lane == Lane_Bits'(Byte_Width - 1);

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    acc_nxt  = acc;
    mask_nxt = mask;
    for (int i = 0; i < Byte_Width; i++) begin
      if (lane == Lane_Bits'(i)) begin
        acc_nxt[8*i +: 8] = byte_dat_i;
        mask_nxt[i]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      lane       <= '0;
      waddr      <= '0;
      acc        <= '0;
      mask       <= '0;
      byte_rdy_o <= 1'b0;
      cen_o      <= 1'b1;
      wen_o      <= '1;
      addr_o     <= '0;
      data_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      cen_o  <= 1'b1;
      wen_o  <= '1;
      done_o <= state == DONE;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            ovf_o  <= 1'b0;
            len    <= len_i;
            waddr  <= base_addr_i;
            cnt    <= '0;
            lane   <= '0;
            acc    <= '0;
            mask   <= '0;
            busy_o <= 1'b1;
            if (len_i != 16'd0) begin
              state      <= PACK;
              byte_rdy_o <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        PACK: begin
          if (fire) begin
            cnt <= cnt + 16'd1;
            if (full || last) begin
              // Output regs take the word; accumulation restarts
              // on the same edge, so packing never bubbles.
              cen_o  <= 1'b0;
              wen_o  <= ~mask_nxt;
              addr_o <= waddr;
              data_o <= acc_nxt;
              acc    <= '0;
              mask   <= '0;
              lane   <= '0;
              waddr  <= waddr + 1'b1;
              if (last) begin
                state      <= FLUSH;
                byte_rdy_o <= 1'b0;
              end
`ifndef PACK_ADDR_WRAP_EN
              else if (&waddr) begin
                state      <= FLUSH;
                byte_rdy_o <= 1'b0;
                ovf_o      <= 1'b1;
              end
`endif
            end else begin
              acc  <= acc_nxt;
              mask <= mask_nxt;
              lane <= lane + 1'b1;
            end
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_be_packer.sv
// tb_ram_be_packer: random and directed jobs checked against a
// word-list model of the packer; one negedge monitor compares writes.
module tb_ram_be_packer;

  localparam int W  = 32;
  localparam int A  = 8;
  localparam int BW = W / 8;

  typedef struct {
    logic [A-1:0]  addr;
    logic [W-1:0]  data;
    logic [BW-1:0] wen;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [A-1:0]  base_addr_i = '0;
  logic [15:0]   len_i = '0;
  logic          byte_val_i = 1'b0;
  logic [7:0]    byte_dat_i = '0;
  logic          byte_rdy_o;
  logic          cen_o;
  logic [BW-1:0] wen_o;
  logic [A-1:0]  addr_o;
  logic [W-1:0]  data_o;
  logic          busy_o;
  logic          done_o;
  logic          ovf_o;

  ram_be_packer #(.Word_Width(W), .Addr_Width(A)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .byte_val_i(byte_val_i), .byte_dat_i(byte_dat_i),
    .byte_rdy_o(byte_rdy_o), .cen_o(cen_o), .wen_o(wen_o),
    .addr_o(addr_o), .data_o(data_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  strobe_cyc = 0;
  int  busy_cyc = 0;
  wr_t exp_q[$];
  wr_t cap_q[$];
  logic [7:0] dat [0:63];
  int  exp_acc;
  bit  exp_ovf;
  int  acc_k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdy_without_busy", 64'(byte_rdy_o & ~busy_o), 64'd0);
      if (!cen_o) begin
        wr_t c;
        c.addr = addr_o;
        c.data = data_o;
        c.wen  = wen_o;
        cap_q.push_back(c);
        strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_write addr=%0h data=%0h", addr_o, data_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(addr_o), 64'(e.addr));
          chk("wr_data", 64'(data_o), 64'(e.data));
          chk("wr_wen", 64'(wen_o), 64'(e.wen));
        end
      end else begin
        chk("idle_wen", 64'(wen_o), {64{1'b0}} | {BW{1'b1}});
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_o) busy_cyc++;
    end
  end

  // Expected writes straight from the job: word w holds bytes
  // w*BW.. at address base+w, only accepted bytes enabled.
  task automatic build_model(input int base, input int len);
    int maxb;
    exp_acc = len;
    exp_ovf = 1'b0;
`ifndef PACK_ADDR_WRAP_EN
    maxb = ((1 << A) - base) * BW;
    if (len > maxb) begin
      exp_acc = maxb;
      exp_ovf = 1'b1;
    end
`endif
    for (int w = 0; w * BW < exp_acc; w++) begin
      wr_t e;
      e.addr = A'(base + w);
      e.data = '0;
      e.wen  = '1;
      for (int l = 0; l < BW; l++) begin
        if (w * BW + l < exp_acc) begin
          e.data[8*l +: 8] = dat[w * BW + l];
          e.wen[l] = 1'b0;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // mode 0: always valid, 1: toggle, 2: random gaps
  task automatic run_job(input int base, input int len, input int mode);
    int d0;
    int budget;
    int st_edge;
    build_model(base, len);
    cap_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = A'(base);
    len_i       = 16'(len);
    st_edge     = cyc + 1;
    busy_cyc    = 0;
    @(negedge clk);
    start_i = 1'b0;
    acc_k   = 0;
    budget  = 0;
    while (done_cnt == d0 && budget < 500) begin
      case (mode)
        0: byte_val_i = acc_k < len;
        1: byte_val_i = (acc_k < len) && (budget % 2 == 0);
        default: byte_val_i = (acc_k < len) && ($urandom_range(0, 3) != 0);
      endcase
      byte_dat_i = (acc_k < len) ? dat[acc_k] : 8'h00;
      if (byte_val_i && byte_rdy_o) acc_k++;
      @(negedge clk);
      budget++;
    end
    byte_val_i = 1'b0;
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout base=%0h len=%0d", base, len);
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("missing_writes", 64'(exp_q.size()), 64'd0);
    chk("bytes_accepted", 64'(acc_k), 64'(exp_acc));
    chk("ovf", 64'(ovf_o), 64'(exp_ovf));
    chk("busy_end", 64'(busy_o), 64'd0);
    if (len == 0) begin
      chk("len0_done_cyc", 64'(done_cyc - st_edge), 64'd1);
      chk("len0_busy_cyc", 64'(busy_cyc), 64'd1);
    end else begin
      chk("done_after_strobe", 64'(done_cyc - strobe_cyc), 64'd2);
    end
    exp_q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_rdy", 64'(byte_rdy_o), 64'd0);
    chk("rst_cen", 64'(cen_o), 64'd1);
    chk("rst_wen", 64'(wen_o), 64'hF);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
  endtask

  initial begin
    int n0;
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) dat[i] = 8'(i + 1);
    run_job('h10, 8, 0);
    chk("lit31_n", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      chk("lit31_a0", 64'(cap_q[0].addr), 64'h10);
      chk("lit31_d0", 64'(cap_q[0].data), 64'h04030201);
      chk("lit31_d1", 64'(cap_q[1].data), 64'h08070605);
      chk("lit31_w1", 64'(cap_q[1].wen), 64'h0);
    end

    for (int i = 0; i < 6; i++) dat[i] = 8'('hA0 + i);
    run_job('h20, 6, 0);
    chk("lit32_n", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      chk("lit32_d0", 64'(cap_q[0].data), 64'hA3A2A1A0);
      chk("lit32_a1", 64'(cap_q[1].addr), 64'h21);
      chk("lit32_d1", 64'(cap_q[1].data), 64'h0000A5A4);
      chk("lit32_w1", 64'(cap_q[1].wen), 64'hC);
    end

    run_job('h33, 0, 0);
    chk("lit33_n", 64'(cap_q.size()), 64'd0);

    for (int i = 0; i < 8; i++) dat[i] = 8'(i + 1);
    run_job('h10, 8, 1);
    chk("lit34_n", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2)
      chk("lit34_d1", 64'(cap_q[1].data), 64'h08070605);

    run_job('hFF, 8, 0);
`ifdef PACK_ADDR_WRAP_EN
    chk("lit35_n", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2)
      chk("lit35_a1", 64'(cap_q[1].addr), 64'h00);
    chk("lit35_ovf", 64'(ovf_o), 64'd0);
`else
    chk("lit35_n", 64'(cap_q.size()), 64'd1);
    chk("lit35_acc", 64'(acc_k), 64'd4);
    chk("lit35_ovf", 64'(ovf_o), 64'd1);
`endif

    // Reset three bytes into a job: partial word must vanish.
    cap_q.delete();
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = 8'h40;
    len_i       = 16'd8;
    @(negedge clk);
    start_i    = 1'b0;
    byte_val_i = 1'b1;
    byte_dat_i = 8'h5A;
    repeat (3) @(negedge clk);
    byte_val_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = cap_q.size();
    repeat (10) @(negedge clk);
    chk("no_write_after_rst", 64'(cap_q.size()), 64'(n0));
    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    run_job('h40, 8, 0);

    for (int j = 0; j < 25; j++) begin
      int b;
      int l;
      b = (j % 4 == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255);
      l = $urandom_range(0, 48);
      for (int i = 0; i < 64; i++) dat[i] = 8'($urandom);
      run_job(b, l, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
